// File: rtl/iob_bus_split_if.sv
// iob_bus_split_if: packed native-bus bundle between the CPU-side
// master port and the N slave ports of the splitter.
interface iob_bus_split_if #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_SLAVES = 2
);
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
    localparam int RESP_W = DATA_W + 1;

    logic [REQ_W-1:0]           m_req;
    logic [RESP_W-1:0]          m_resp;
    logic [N_SLAVES*REQ_W-1:0]  s_req;
    logic [N_SLAVES*RESP_W-1:0] s_resp;

    modport master (
        output m_req,
        input  m_resp,
        input  s_req,
        output s_resp
    );

    modport slave (
        input  m_req,
        output m_resp,
        output s_req,
        input  s_resp
    );
endinterface

// File: rtl/iob_bus_split.sv
// iob_bus_split: 1-to-N native bus splitter with route lock,
// decode-error responses and a per-transaction timeout watchdog.
module iob_bus_split #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_SLAVES = 2,
    parameter int SEL_W    = 1,
    parameter int TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic             clk,
    input  logic             rst,
    iob_bus_split_if.slave   bus,
    input  logic             err_clr,
    output logic             err_flag,
    output logic [1:0]       err_code,
    output logic [SEL_W-1:0] err_sel
);
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
    localparam int RESP_W = DATA_W + 1;
    localparam int CNT_W  =
        (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] CODE_DEC = 2'b01;
    localparam logic [1:0] CODE_TMO = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ERR
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [SEL_W-1:0]   sel_q;
    logic               rst_q;

    logic               m_valid;
    logic [SEL_W-1:0]   sel;
    logic               sel_ok;
    logic               active;
    logic               route_en;
    logic [SEL_W-1:0]   route_sel;
    logic               rdy;
    logic [N_SLAVES*REQ_W-1:0] s_req_d;
    logic [RESP_W-1:0]  m_resp_d;

    assign m_valid = bus.m_req[REQ_W-1];
    assign sel     = bus.m_req[REQ_W-2 -: SEL_W];
    assign sel_ok  = (32'(sel) < N_SLAVES);

    // Outputs stay quiet during reset and the cycle right after it.
    assign active  = !rst && !rst_q;

    always_comb begin
        route_en  = 1'b0;
        route_sel = sel;
        if (active) begin
            unique case (state)
                IDLE: begin
                    route_en  = m_valid && sel_ok;
                    route_sel = sel;
                end
                BUSY: begin
                    route_en  = m_valid;
                    route_sel = sel_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_req_d  = '0;
        m_resp_d = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (route_en && route_sel == SEL_W'(k)) begin
                s_req_d[k*REQ_W +: REQ_W] = bus.m_req;
                m_resp_d = bus.s_resp[k*RESP_W +: RESP_W];
            end
        end
        if (active && state == ERR)
            m_resp_d = {ERR_DATA, 1'b1};
    end

    assign rdy        = route_en && m_resp_d[0];
    assign bus.s_req  = s_req_d;
    assign bus.m_resp = m_resp_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sel_q    <= '0;
            rst_q    <= 1'b1;
            err_flag <= 1'b0;
            err_code <= '0;
            err_sel  <= '0;
        end else begin
            rst_q <= 1'b0;
            if (err_clr) begin
                err_flag <= 1'b0;
                err_code <= '0;
                err_sel  <= '0;
            end
            unique case (state)
                IDLE: begin
                    if (active && m_valid) begin
                        if (!sel_ok) begin
                            state <= ERR;
                            if (!err_flag || err_clr) begin
                                err_flag <= 1'b1;
                                err_code <= CODE_DEC;
                                err_sel  <= sel;
                            end
                        end else if (!rdy) begin
                            state <= BUSY;
                            sel_q <= sel;
                            cnt   <= '0;
                        end
                    end
                end
                BUSY: begin
                    // Ready at the limit completes normally.
                    if (!m_valid || rdy) begin
                        state <= IDLE;
                    end else if (TIMEOUT > 0 &&
                        cnt == CNT_W'(TIMEOUT - 1)) begin
                        state <= ERR;
                        if (!err_flag || err_clr) begin
                            err_flag <= 1'b1;
                            err_code <= CODE_TMO;
                            err_sel  <= sel_q;
                        end
                    end else if (TIMEOUT > 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iob_bus_split.sv
// tb_iob_bus_split: directed plus randomized transactions checked
// against a transaction-level model of the splitter.
module tb_iob_bus_split;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int N      = 3;
    localparam int SEL_W  = 2;
    localparam int TO     = 8;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
    localparam int RESP_W = DATA_W + 1;
    localparam logic [31:0] ERR_D = 32'hDEADBEEF;
    localparam int NEVER  = 100000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             err_clr = 1'b0;
    logic             err_flag;
    logic [1:0]       err_code;
    logic [SEL_W-1:0] err_sel;

    iob_bus_split_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLAVES(N)
    ) bus ();

    iob_bus_split #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLAVES(N),
        .SEL_W(SEL_W), .TIMEOUT(TO), .ERR_DATA(ERR_D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .err_clr(err_clr),
        .err_flag(err_flag),
        .err_code(err_code),
        .err_sel(err_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [79:0] got,
                       input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Slave k raises ready once its valid has been high lat[k] cycles.
    int            lat  [N];
    logic [31:0]   rd   [N];
    int            scnt [N];
    logic [N-1:0]  sv;

    always_comb begin
        bus.s_resp = '0;
        sv = '0;
        for (int k = 0; k < N; k++) begin
            sv[k] = bus.s_req[k*REQ_W + REQ_W - 1];
            bus.s_resp[k*RESP_W +: RESP_W] =
                {rd[k], sv[k] && (scnt[k] == lat[k])};
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst || !sv[k] || bus.s_resp[k*RESP_W])
                scnt[k] <= 0;
            else
                scnt[k] <= scnt[k] + 1;
        end
    end

    bit         ef;
    logic [1:0] ec;
    int         es;

    task automatic rec(input logic [1:0] code, input int s,
                       input bit clr);
        if (!ef || clr) begin
            ef = 1'b1;
            ec = code;
            es = s;
        end
    endtask

    task automatic chk_status();
        chk("err_flag", err_flag, ef);
        chk("err_code", err_code, ec);
        chk("err_sel", err_sel, es[SEL_W-1:0]);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_s_req"}, bus.s_req, '0);
        chk({tag, "_m_resp"}, bus.m_resp, '0);
    endtask

    task automatic txn(input logic [31:0] addr,
                       input logic [31:0] wd,
                       input logic [3:0]  ws,
                       input int abort_at, input bit chg,
                       input bit clr);
        int sel;
        bit dec;
        bit done;
        bit sv_e;
        logic [RESP_W-1:0] rsp_e;
        logic [REQ_W-1:0]  req;
        logic [79:0]       exp_k;
        sel  = int'(addr[31:30]);
        dec  = (sel >= N);
        req  = {1'b1, addr, wd, ws};
        done = 1'b0;
        for (int c = 0; c <= TO + 1 && !done; c++) begin
            @(posedge clk); #1;
            if (chg && c > 0)
                req[REQ_W-2 -: ADDR_W] = $urandom;
            if (c == abort_at)
                req[REQ_W-1] = 1'b0;
            err_clr = clr && dec && (c == 0);
            bus.m_req = req;
            @(negedge clk);
            sv_e  = 1'b0;
            rsp_e = '0;
            if (dec) begin
                if (c == 1) begin
                    rsp_e = {ERR_D, 1'b1};
                    done  = 1'b1;
                    rec(2'b01, sel, clr);
                end
            end else if (c == abort_at) begin
                done = 1'b1;
            end else if (c > TO) begin
                rsp_e = {ERR_D, 1'b1};
                done  = 1'b1;
                rec(2'b10, sel, 1'b0);
            end else begin
                sv_e  = 1'b1;
                rsp_e = {rd[sel], c == lat[sel]};
                done  = (c == lat[sel]);
            end
            for (int k = 0; k < N; k++) begin
                exp_k = (k == sel && sv_e) ? 80'(req) : 80'd0;
                chk($sformatf("s_req%0d_c%0d", k, c),
                    bus.s_req[k*REQ_W +: REQ_W], exp_k);
            end
            chk($sformatf("m_resp_c%0d", c), bus.m_resp, rsp_e);
        end
        @(posedge clk); #1;
        bus.m_req = '0;
        err_clr   = 1'b0;
        @(negedge clk);
        chk_quiet("idle");
        chk_status();
    endtask

    task automatic clr_cycle();
        @(posedge clk); #1;
        err_clr   = 1'b1;
        bus.m_req = '0;
        @(negedge clk);
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        ef = 1'b0;
        ec = 2'b00;
        es = 0;
        chk_status();
    endtask

    logic [REQ_W-1:0] rreq;
    logic [31:0]      ra;
    int               rs;
    int               ab;
    int               top;

    initial begin
        for (int k = 0; k < N; k++) begin
            lat[k] = 0;
            rd[k]  = 32'h0;
        end
        ef = 1'b0;
        ec = 2'b00;
        es = 0;
        rreq = {1'b1, 32'h4000_0000, 32'h0, 4'h0};
        bus.m_req = rreq;

        repeat (2) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk_quiet("rst");
            chk_status();
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_rst");
        @(posedge clk); #1;
        bus.m_req = '0;
        @(negedge clk);
        chk_quiet("post_rst_idle");

        lat[1] = 0;
        rd[1]  = 32'h1234_5678;
        txn(32'h4000_0010, 32'h0, 4'h0, -1, 1'b0, 1'b0);

        lat[2] = 3;
        rd[2]  = 32'h0BAD_F00D;
        txn(32'h8000_0004, 32'hA5A5_A5A5, 4'hF, -1, 1'b1, 1'b0);

        txn(32'hC000_0000, 32'h0, 4'h0, -1, 1'b0, 1'b0);
        clr_cycle();

        lat[0] = NEVER;
        rd[0]  = 32'h7777_0000;
        txn(32'h0000_0100, 32'h0, 4'h0, -1, 1'b0, 1'b0);
        txn(32'hC000_0000, 32'h0, 4'h0, -1, 1'b0, 1'b0);
        clr_cycle();

        lat[0] = TO;
        rd[0]  = 32'h0000_CAFE;
        txn(32'h0000_0200, 32'h0, 4'h0, -1, 1'b0, 1'b0);

        txn(32'hC000_0000, 32'h0, 4'h0, -1, 1'b0, 1'b0);
        lat[0] = NEVER;
        txn(32'h0000_0000, 32'h0, 4'h0, -1, 1'b0, 1'b0);
        txn(32'hC000_0008, 32'h0, 4'h0, -1, 1'b0, 1'b1);

        lat[1] = NEVER;
        rreq = {1'b1, 32'h4000_0000, 32'h1111_2222, 4'h3};
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            bus.m_req = rreq;
            @(negedge clk);
            chk("busy_s_req1", bus.s_req[REQ_W +: REQ_W], rreq);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        ef = 1'b0;
        ec = 2'b00;
        es = 0;
        chk_quiet("mid_post_rst");
        chk_status();
        @(posedge clk); #1;
        bus.m_req = '0;
        lat[1] = 2;
        @(negedge clk);
        txn(32'h4000_0000, 32'h0, 4'h0, -1, 1'b0, 1'b0);

        for (int t = 0; t < 200; t++) begin
            for (int k = 0; k < N; k++) begin
                rd[k]  = $urandom;
                lat[k] = ($urandom_range(0, 7) == 0) ?
                    NEVER : int'($urandom_range(0, 10));
            end
            ra = $urandom;
            rs = int'(ra[31:30]);
            ab = -1;
            if (rs < N && lat[rs] >= 2 &&
                $urandom_range(0, 5) == 0) begin
                top = (lat[rs] - 1 < TO) ? lat[rs] - 1 : TO;
                ab  = int'($urandom_range(1, top));
            end
            txn(ra, $urandom, 4'($urandom), ab,
                1'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 5) == 0)
                clr_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/iob_bus_split.md
Name: iob_bus_split

Overview:
- Parametrised 1-to-N native-bus splitter placed between a CPU-side master port (valid/addr/wdata/wstrb request, rdata/ready response) and N slave ports (memories, peripherals, DDR).
- Decodes the slave from the top address bits and locks the route for the whole transaction.
- Adds a per-transaction timeout watchdog and decode-error responses, so the CPU never hangs on an unmapped or dead slave.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; wstrb width is DATA_W/8
N_SLAVES, 2, number of slave ports, >=2
SEL_W, 1, number of top address bits used as slave index; must satisfy 2**SEL_W >= N_SLAVES
TIMEOUT, 255, cycles a slave may stall before an error response; 0 disables the watchdog
ERR_DATA, 32'hDEADBEEF, rdata returned on an error response
Derived: REQ_W = 1+ADDR_W+DATA_W+DATA_W/8; RESP_W = DATA_W+1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m_req  in  REQ_W  master request, packed MSB-first as {valid, addr, wdata, wstrb}
m_resp  out  RESP_W  master response, packed {rdata, ready}; ready is the LSB
s_req  out  N_SLAVES*REQ_W  slave requests; slave k occupies bits [k*REQ_W +: REQ_W]
s_resp  in  N_SLAVES*RESP_W  slave responses; same packing as m_resp
err_clr  in  1  clears the sticky error status
err_flag  out  1  sticky: an error response has occurred
err_code  out  2  01 = decode error, 10 = timeout; holds the first error since the last clear
err_sel  out  SEL_W  slave index of the first error

Behaviour:
- Clock, reset and polarity: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: FSM=IDLE, counter=0, sel_q=0, err_flag=0, err_code=0, err_sel=0. All s_req and m_resp drive zero during rst and in the cycle after reset.
- Decode: sel = addr[ADDR_W-1 -: SEL_W]. The selection is invalid when sel >= N_SLAVES.
- Unselected slaves always receive an all-zero request. Ready from an unselected slave is ignored.
- FSM state IDLE:
  - m_valid=0: all outputs zero.
  - m_valid=1 with a valid sel: forward m_req combinationally to s_req[sel] and return s_resp[sel] on m_resp.
    - If the slave is ready in the same cycle, the transaction completes with zero latency and the FSM stays in IDLE.
    - Otherwise register sel_q=sel, clear the counter and go to BUSY.
  - m_valid=1 with an invalid sel: no slave request is issued; go to ERR with err cause = decode.
- FSM state BUSY:
  - Forward m_req only to s_req[sel_q]. Address changes from the master do not re-route the request.
  - m_resp = s_resp[sel_q]. When that slave's ready=1, return to IDLE.
  - If the master drops valid, the slave request also drops, and the FSM returns to IDLE in the next cycle.
  - With TIMEOUT>0, the counter increments each BUSY cycle. When counter == TIMEOUT-1 and ready=0, deassert the slave valid from the next cycle and go to ERR with cause = timeout.
  - If ready arrives in the same cycle the limit is reached, ready wins: normal completion, no error.
- FSM state ERR: lasts exactly one cycle. m_resp = {ERR_DATA, 1'b1} and all s_req are zero. The FSM then goes to IDLE.
- Sticky status:
  - On entry to ERR, if err_flag=0, set err_flag=1 and latch err_code and err_sel (for a decode error, err_sel is the decoded sel).
  - Later errors do not overwrite the status until it is cleared.
  - err_clr=1 clears the status next cycle. If err_clr coincides with a new error, the new error is recorded.
- Widths: the counter is wide enough to hold TIMEOUT (clog2(TIMEOUT+1), minimum 1). With TIMEOUT=0 the counter is held at 0 and ERR is reached only through a decode error.
- Reset mid-transaction: the FSM returns to IDLE immediately and the pending slave request drops. No error is recorded.
- Write and read transactions are treated identically. wstrb and wdata pass through unmodified.

Test Plan (ADDR_W=32, DATA_W=32, N_SLAVES=3, SEL_W=2, TIMEOUT=8):
1. Zero-latency read: slave 1 has ready tied to valid with rdata=32'h1234_5678; master reads addr 32'h4000_0010 -> s_req[1] valid in the same cycle, m_resp={32'h12345678,1} in the same cycle, s_req[0] and s_req[2] zero, FSM stays IDLE.
2. Stalled write with route lock: write 32'hA5A5A5A5 (wstrb=4'hF) to 32'h8000_0004; slave 2 answers ready after 3 cycles while the master changes addr to 32'h0000_0000 during the wait -> only s_req[2] is valid for 4 cycles, completes on cycle 4, s_req[0] stays zero.
3. Decode error: read at 32'hC000_0000 (sel=3) -> no slave valid, m_resp={32'hDEADBEEF,1} one cycle later, err_flag=1, err_code=01, err_sel=3.
4. Timeout and sticky status: slave 0 never asserts ready, read 32'h0000_0100 -> error response after 8 wait cycles, s_req[0] valid drops, err_code=10, err_sel=0. A subsequent decode error does not change err_code. After err_clr, err_flag=0 and err_code=00.
5. Ready at the limit: slave 0 asserts ready in exactly the 8th wait cycle -> normal completion with slave rdata, err_flag stays 0.
6. Reset mid-BUSY: assert rst while waiting on slave 1 -> next cycle all s_req and m_resp are zero, FSM=IDLE, err_flag=0. A new read to slave 1 then completes normally.
